div_sequencer: RTL and testbench
================================

Name: div_sequencer

Overview:
Multi-cycle sequencer for the DIV/DIVU resource used by the EX stage. It accepts a divide request from the pipeline and runs an iterative restoring divider, one quotient bit per cycle. It holds the pipeline via a stall request until the result is ready, then presents quotient and remainder for the HI/LO write path in ME/WB. It also honours pipeline flush (annul) and external stalls.

Parameters:
WIDTH, 32, operand/result width in bits
ITERS, WIDTH, iteration count (one quotient bit per cycle)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-low reset (0 = reset)
start  input  1  divide request from EX (isdivE), level-sensitive
signed_div  input  1  1 = DIV (signed), 0 = DIVU; sampled with start
opdata1  input  WIDTH  dividend (rs), sampled with start
opdata2  input  WIDTH  divisor (rt), sampled with start
annul  input  1  cancel current op (flushE/exception)
pipe_stall  input  1  external pipeline stall; holds the DONE result
result_lo  output  WIDTH  quotient -> LO
result_hi  output  WIDTH  remainder -> HI
ready  output  1  result valid this cycle
stall_req  output  1  stall request to the hazard/stall logic

Behaviour:
- States: IDLE, ZERO, BUSY, DONE. The 2-bit state encoding is in the package.
- Reset (rst=0 at a clock edge): state=IDLE; counter, result_lo, result_hi and internal regs all 0. Reset mid-operation aborts the divide with no result.
- IDLE, start=1 and annul=0:
  - Latch the operands.
  - If divisor==0, go to ZERO.
  - Otherwise latch |dividend| and |divisor| (magnitude only when signed_div=1 and the operand is negative), latch sign_q = sign(op1) XOR sign(op2) and sign_r = sign(op1), clear the counter, and go to BUSY.
- IDLE, start=0 or annul=1: stay in IDLE.
- ZERO: go to DONE with result_lo=0 and result_hi=0. Latency is 2 cycles from start to ready.
- BUSY, per cycle:
  - {rem, quo} shifted left by 1.
  - If rem_shifted >= divisor: rem -= divisor and quotient LSB = 1.
  - Counter increments.
  - When the counter reaches ITERS-1, go to DONE.
  - The remainder register is WIDTH+1 bits wide to avoid compare overflow.
- DONE entry: sign correction is applied on the transition into DONE.
  - result_lo = sign_q ? -quo : quo.
  - result_hi = sign_r ? -rem : rem.
  - Arithmetic is two's complement modulo 2^WIDTH.
- DONE timing: normal latency is start seen in IDLE at cycle T, BUSY for cycles T+1..T+32, DONE at T+33.
- DONE: ready=1. If pipe_stall=1, stay in DONE with results frozen. If pipe_stall=0, go to IDLE next cycle. start is ignored in DONE (it is the same instruction still in EX).
- Outputs:
  - stall_req = !annul AND ((state==IDLE AND start) OR state==ZERO OR state==BUSY).
  - stall_req is combinational, so the instruction is held from its first EX cycle.
  - ready = (state==DONE).
  - result_lo and result_hi are registered and hold their last value in IDLE.
- annul=1 in ZERO, BUSY or DONE: go to IDLE next cycle, no ready pulse. annul overrides pipe_stall.
- A back-to-back divide is accepted in the IDLE cycle immediately after DONE.
- Signed overflow 0x80000000 / -1 yields lo=0x80000000, hi=0 (modulo wrap, no trap).

Decomposition:
- Package div_pkg holds:
  - the state enum (IDLE, ZERO, BUSY, DONE)
  - DIV_WIDTH=32
  - DIV_CNT_W = clog2(ITERS)
- Sub-module div_step: a combinational single shift-subtract iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - It is instantiated once inside div_sequencer.
- The FSM, counter and sign correction stay in div_sequencer.

Test Plan:
- Unsigned: DIVU 100/7, start at T -> stall_req=1 for T..T+32; at T+33 ready=1, lo=14, hi=2, stall_req=0; IDLE at T+34.
- Signed: DIV -7/2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then DIV 7/-2 -> lo=0xFFFFFFFD, hi=1.
- Corners:
  - DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
  - DIVU 0xFFFFFFFF/1 -> lo=0xFFFFFFFF, hi=0.
  - DIVU 5/0 -> ready at T+2, lo=0, hi=0.
- Annul: start DIVU 1000/3, assert annul at BUSY iteration 10 -> stall_req=0 that cycle, IDLE next cycle, no ready. A new DIVU 9/4 then returns lo=2, hi=1 after 33 cycles.
- Hold and reset:
  - pipe_stall=1 for 3 cycles in DONE -> ready and results held 4 cycles total; start held high is not re-accepted until IDLE.
  - rst=0 mid-BUSY -> IDLE, outputs 0 next edge.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative DIV/DIVU sequencer.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_ITERS = DIV_WIDTH;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_ITERS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ZERO = 2'd1,
    BUSY = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage : div_pkg

// File: rtl/div_sequencer_if.sv
// Pipeline <-> divider handshake: request/operands in, quotient/remainder out.
interface div_sequencer_if
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
);

  logic             start;
  logic             signed_div;
  logic [WIDTH-1:0] opdata1;
  logic [WIDTH-1:0] opdata2;
  logic             annul;
  logic             pipe_stall;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             ready;
  logic             stall_req;

  // Pipeline (EX / hazard logic) side
  modport master (
    output start, signed_div, opdata1, opdata2, annul, pipe_stall,
    input  result_lo, result_hi, ready, stall_req
  );

  // Divider side
  modport slave (
    input  start, signed_div, opdata1, opdata2, annul, pipe_stall,
    output result_lo, result_hi, ready, stall_req
  );

endinterface : div_sequencer_if

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, subtract divisor if it fits.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] dvs_ext;

  // Trial subtraction on the shifted partial remainder; extra MSB keeps the compare exact
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    dvs_ext = {2'b00, dvs_i};
    quo_o   = {quo_i[WIDTH-2:0], 1'b0};
    rem_o   = (WIDTH+1)'(shifted);
    if (shifted >= dvs_ext) begin
      rem_o = (WIDTH+1)'(shifted - dvs_ext);
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule : div_step

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU sequencer: stalls EX while a restoring divider runs,
// then presents sign-corrected quotient (LO) and remainder (HI).
module div_sequencer
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned ITERS = WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  div_sequencer_if.slave  bus
);

  localparam int unsigned CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;

  logic             op1_neg, op2_neg;
  logic [WIDTH-1:0] op1_mag, op2_mag;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] step_rem_w;

  // Operand magnitudes; only negative operands of a signed divide are negated
  assign op1_neg    = bus.signed_div & bus.opdata1[WIDTH-1];
  assign op2_neg    = bus.signed_div & bus.opdata2[WIDTH-1];
  assign op1_mag    = op1_neg ? (WIDTH'(0) - bus.opdata1) : bus.opdata1;
  assign op2_mag    = op2_neg ? (WIDTH'(0) - bus.opdata2) : bus.opdata2;
  assign step_rem_w = WIDTH'(step_rem);

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      lo_q      <= '0;
      hi_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
    end
  end

  // Next-state, iteration and sign-correction logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    lo_d      = lo_q;
    hi_d      = hi_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.annul) begin
          cnt_d = '0;
          rem_d = '0;
          if (bus.opdata2 == '0) begin
            // Divide by zero skips the iterations and returns zeros
            quo_d     = bus.opdata1;
            dvs_d     = bus.opdata2;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = ZERO;
          end else begin
            quo_d     = op1_mag;
            dvs_d     = op2_mag;
            neg_quo_d = op1_neg ^ op2_neg;
            neg_rem_d = op1_neg;
            state_d   = BUSY;
          end
        end
      end

      ZERO: begin
        if (bus.annul) begin
          state_d = IDLE;
        end else begin
          lo_d    = '0;
          hi_d    = '0;
          state_d = DONE;
        end
      end

      BUSY: begin
        if (bus.annul) begin
          state_d = IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = CNT_W'(cnt_q + 1'b1);
          if (cnt_q == CNT_W'(ITERS - 1)) begin
            // Final iteration: apply signs while entering DONE (wraps modulo 2^WIDTH)
            lo_d    = neg_quo_q ? (WIDTH'(0) - step_quo)   : step_quo;
            hi_d    = neg_rem_q ? (WIDTH'(0) - step_rem_w) : step_rem_w;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        // start is ignored here: it is still the same instruction in EX
        if (bus.annul || !bus.pipe_stall) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Stall is combinational so the divide instruction is held from its first EX cycle
  assign bus.stall_req = !bus.annul &&
                         (((state_q == IDLE) && bus.start) ||
                          (state_q == ZERO) || (state_q == BUSY));
  assign bus.ready     = (state_q == DONE);
  assign bus.result_lo = lo_q;
  assign bus.result_hi = hi_q;

endmodule : div_sequencer

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: directed divides, corners, annul, hold, reset.
module tb_div_sequencer;

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  exp_t exp_q[$];
  exp_t cur;
  logic rdy_prev;

  div_sequencer_if #(.WIDTH(32)) bus ();

  div_sequencer #(
    .WIDTH (32),
    .ITERS (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Monitor: pop on the first ready cycle, then require frozen results while ready stays high
  always @(negedge clk) begin
    if (bus.ready) begin
      if (!rdy_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ready", 64'd1, 64'd0);
        end else begin
          cur = exp_q.pop_front();
          check("result_lo", 64'(bus.result_lo), 64'(cur.lo));
          check("result_hi", 64'(bus.result_hi), 64'(cur.hi));
        end
      end else begin
        check("held_lo", 64'(bus.result_lo), 64'(cur.lo));
        check("held_hi", 64'(bus.result_hi), 64'(cur.hi));
      end
    end
    rdy_prev = bus.ready;
  end

  // Wait (bounded) for ready, counting cycles from the request cycle and stall cycles
  task automatic wait_ready(output int lat, output int stl, output bit ok);
    ok  = 1'b0;
    lat = 0;
    stl = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.ready) begin
        ok  = 1'b1;
        lat = i;
      end else begin
        if (bus.stall_req) stl++;
        @(posedge clk);
        #1;
      end
    end
    if (!ok) check("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic push_exp(input logic [31:0] lo, input logic [31:0] hi);
    exp_t e;
    e.lo = lo;
    e.hi = hi;
    exp_q.push_back(e);
  endtask

  task automatic do_div(input string nm, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] lo,
                        input logic [31:0] hi, input int exp_lat);
    int lat;
    int stl;
    bit ok;
    @(posedge clk);
    #1;
    push_exp(lo, hi);
    bus.start      = 1'b1;
    bus.signed_div = sgn;
    bus.opdata1    = a;
    bus.opdata2    = b;
    wait_ready(lat, stl, ok);
    if (ok) begin
      check({nm, "_latency"}, 64'(lat), 64'(exp_lat));
      check({nm, "_stall_cycles"}, 64'(stl), 64'(exp_lat));
      check({nm, "_stall_at_ready"}, 64'(bus.stall_req), 64'd0);
    end
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check({nm, "_idle_after"}, 64'(bus.ready), 64'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int lat;
    int stl;
    bit ok;
    n_checks = 0;
    n_fail   = 0;
    rdy_prev = 1'b0;
    rst            = 1'b0;
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.opdata1    = '0;
    bus.opdata2    = '0;
    bus.annul      = 1'b0;
    bus.pipe_stall = 1'b0;
    idle_cycles(3);
    rst = 1'b1;
    @(negedge clk);
    check("reset_ready", 64'(bus.ready), 64'd0);
    check("reset_stall", 64'(bus.stall_req), 64'd0);
    check("reset_lo", 64'(bus.result_lo), 64'd0);
    check("reset_hi", 64'(bus.result_hi), 64'd0);

    // Main function and corners
    do_div("divu_100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33);
    do_div("div_m7_2",     1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33);
    do_div("div_7_m2",     1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33);
    do_div("div_ovf",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33);
    do_div("divu_max_1",   1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33);
    do_div("divu_5_0",     1'b0, 32'd5,          32'd0,          32'd0,          32'd0,          2);
    do_div("div_m5_0",     1'b1, 32'hFFFF_FFFB,  32'd0,          32'd0,          32'd0,          2);
    do_div("div_m100_m7",  1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  33);

    // Annul at BUSY iteration 10 (11 cycles after the request cycle)
    @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.signed_div = 1'b0;
    bus.opdata1    = 32'd1000;
    bus.opdata2    = 32'd3;
    idle_cycles(11);
    bus.annul = 1'b1;
    @(negedge clk);
    check("annul_stall", 64'(bus.stall_req), 64'd0);
    @(posedge clk);
    #1;
    bus.annul = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("annul_ready", 64'(bus.ready), 64'd0);
    check("annul_idle_stall", 64'(bus.stall_req), 64'd0);
    idle_cycles(40);
    do_div("divu_9_4", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 33);

    // pipe_stall holds DONE; start stays high and is only re-accepted back in IDLE
    @(posedge clk);
    #1;
    push_exp(32'd14, 32'd2);
    bus.start      = 1'b1;
    bus.signed_div = 1'b0;
    bus.opdata1    = 32'd100;
    bus.opdata2    = 32'd7;
    wait_ready(lat, stl, ok);
    if (ok) check("hold_latency", 64'(lat), 64'd33);
    bus.pipe_stall = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      if (k == 3) begin
        bus.pipe_stall = 1'b0;
        bus.opdata1    = 32'd9;
        bus.opdata2    = 32'd4;
        push_exp(32'd2, 32'd1);
      end
      @(negedge clk);
      check("hold_ready", 64'(bus.ready), 64'd1);
    end
    @(posedge clk);
    #1;
    wait_ready(lat, stl, ok);
    if (ok) begin
      check("b2b_latency", 64'(lat), 64'd33);
      check("b2b_stall_cycles", 64'(stl), 64'd33);
    end
    bus.start = 1'b0;
    idle_cycles(2);

    // Reset in the middle of BUSY aborts with zeroed outputs and no result
    @(posedge clk);
    #1;
    bus.start   = 1'b1;
    bus.opdata1 = 32'd100;
    bus.opdata2 = 32'd7;
    idle_cycles(5);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_lo", 64'(bus.result_lo), 64'd0);
    check("midrst_hi", 64'(bus.result_hi), 64'd0);
    check("midrst_ready", 64'(bus.ready), 64'd0);
    check("midrst_stall", 64'(bus.stall_req), 64'd0);
    idle_cycles(40);
    do_div("post_rst_divu", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 33);

    idle_cycles(2);
    check("pending_results", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_div_sequencer
